hazard_stall_unit: RTL

Pipeline hazard controller that generates the 2-bit stall/flush codes consumed by the inter-stage latches (00 pass, 01 hold, 10 flush-to-bubble) and the PC hold. It detects load-use hazards, taken branches resolved in EX, multi-cycle divides and data-memory wait states, and sequences the divide stall with an internal FSM and counter. It sits beside the datapath. Its outputs are sampled by the IF/ID, ID/EX, EX/MEM and MEM/WB latches and by the PC register on the next rising edge. It also keeps saturating stall and flush performance counters.

---
 rtl/hazard_stall_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: decodes load-use, branch, divide and memory-wait
// hazards into per-latch stall/flush codes, sequences divide stalls, counts stalls.
module hazard_stall_unit #(
  parameter int unsigned DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_use_rs,
  input  logic        ID_use_rt,
  input  logic [4:0]  EX_rd,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic        EX_branch_taken,
  input  logic        EX_div,
  input  logic        mem_busy,
  output logic        pc_hold,
  output logic [1:0]  IF_shouldstall,
  output logic [1:0]  ID_EX_ctrl,
  output logic [1:0]  EX_MEM_ctrl,
  output logic [1:0]  MEM_WB_ctrl,
  output logic        div_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {S_RUN, S_DIV, S_DONE} state_t;

  localparam logic [1:0] C_PASS  = 2'b00;
  localparam logic [1:0] C_HOLD  = 2'b01;
  localparam logic [1:0] C_FLUSH = 2'b10;

  state_t     state;
  logic [7:0] cnt;
  logic       div_stall;
  logic       load_use;
  logic       flush_issue;

  assign div_stall = (state == S_RUN && EX_div) || (state == S_DIV);

  // $0 is hard-wired zero, so a pending write to it is never a real dependency.
  assign load_use = EX_MemRead && EX_RegWrite && (EX_rd != 5'd0) &&
                    ((ID_use_rs && ID_rs == EX_rd) || (ID_use_rt && ID_rt == EX_rd));

  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // if-chain leaves a signal unassigned, which would infer a latch.
    pc_hold        = 1'b0;
    IF_shouldstall = C_PASS;
    ID_EX_ctrl     = C_PASS;
    EX_MEM_ctrl    = C_PASS;
    MEM_WB_ctrl    = C_PASS;
    flush_issue    = 1'b0;
    if (!rst) begin
      pc_hold = 1'b0;
    end else if (mem_busy) begin
      pc_hold        = 1'b1;
      IF_shouldstall = C_HOLD;
      ID_EX_ctrl     = C_HOLD;
      EX_MEM_ctrl    = C_HOLD;
      MEM_WB_ctrl    = C_FLUSH;
    end else if (div_stall) begin
      pc_hold        = 1'b1;
      IF_shouldstall = C_HOLD;
      ID_EX_ctrl     = C_HOLD;
      EX_MEM_ctrl    = C_FLUSH;
    end else if (EX_branch_taken) begin
      IF_shouldstall = C_FLUSH;
      ID_EX_ctrl     = C_FLUSH;
      flush_issue    = 1'b1;
    end else if (load_use) begin
      pc_hold        = 1'b1;
      IF_shouldstall = C_HOLD;
      ID_EX_ctrl     = C_FLUSH;
    end
  end

  assign div_done = rst && (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
      cnt   <= 8'd0;
    end else if (!mem_busy) begin
      unique case (state)
        S_RUN: if (EX_div) begin
          state <= S_DIV;
          cnt   <= 8'(DIV_LAT - 1);
        end
        S_DIV: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= S_DONE;
        end
        S_DONE:  state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (pc_hold && stall_cnt != 32'hFFFF_FFFF)     stall_cnt <= stall_cnt + 32'd1;
      if (flush_issue && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule
